zx_frame_loader: RTL and testbench
==================================

Name: zx_frame_loader

Overview:
- Sequences SPI screen uploads into a double-buffered ZX frame RAM, entirely in the pixel-clock domain.
- Oversamples the raw SPI pins (spi_clk, spi_dat, spi_cs) and assembles bytes MSB-first.
- Issues one RAM write per byte into the back bank; latches the border register.
- Commits a complete frame to the display bank at the next vsync, so the renderer never shows a torn frame.

Parameters:
- PIXEL_BYTES, 6144, ZX bitmap bytes (256x192/8)
- ATTR_BYTES, 768, attribute bytes
- INFO_BYTES, 256, info/text area bytes
- FRAME_BYTES, PIXEL_BYTES+ATTR_BYTES+INFO_BYTES (7168), bytes per frame
- BORDER_OFFSET, 7040, frame byte index whose bits [2:0] are the border colour
- AW, 13, byte index width (must satisfy 2^AW >= FRAME_BYTES)

Ports:
- PixelClk  in  1  pixel clock, sole clock
- RST  in  1  asynchronous active-high reset
- spi_clk  in  1  raw SPI clock; must be at most PixelClk/4
- spi_dat  in  1  raw SPI data, sampled on spi_clk rising
- spi_cs  in  1  raw SPI chip select, active low
- vsync  in  1  display vsync, synchronous to PixelClk
- wr_en  out  1  RAM write strobe, one cycle per byte
- wr_addr  out  AW+1  {bank, byte index}
- wr_data  out  8  byte to write
- rd_bank  out  1  bank the renderer must read
- border  out  3  committed border colour {G,R,B}
- frame_cnt  out  8  committed frames, wraps
- short_err  out  1  one-cycle pulse: cs released mid-frame
- drop_cnt  out  8  frames skipped because a commit was pending; saturates at 255

Behaviour:
- Reset values: wr_en 0, wr_addr 0, wr_data 0, rd_bank 0, write bank 1, border 3'b111, frame_cnt 0, drop_cnt 0, short_err 0, state IDLE.
- Synchronizer reset values: spi_clk 0, spi_cs 1, spi_dat 0.
- Input sync: 2-FF synchronizer on each SPI pin. Edge detect on synced clk/cs against a third register.
- States:
  - IDLE: on cs falling, go to RECV if not pending, else SKIP and drop_cnt++.
  - RECV: count bits and bytes.
  - DONE: full frame received; any further bytes are ignored (no wr_en). Go to IDLE on cs rising.
  - SKIP: ignore all bits; go to IDLE on cs rising.
- Entering RECV clears bit count and byte index to 0.
- Byte assembly (RECV, synced clk rising, cs low): shift synced data in at the LSB.
- On the 8th bit, the next cycle drives wr_en=1, wr_data=byte, wr_addr={~rd_bank, idx}; idx increments after the write.
- Latency: the write strobe occurs 4 PixelClk cycles after the raw spi_clk rising edge (2 sync + 1 edge + 1 output register).
- When idx==BORDER_OFFSET is written, border_shadow <= byte[2:0].
- When idx==FRAME_BYTES-1 is written: set pending, go to DONE.
- cs rising in RECV before the frame completes:
  - short_err pulses for 1 cycle; go to IDLE.
  - Partial bits are discarded; no write for an incomplete byte.
  - pending is not set; bytes already written stay in the back bank, which is never displayed.
- Commit: on vsync rising edge (registered compare) with pending=1, in the same cycle:
  - rd_bank toggles; border <= border_shadow; frame_cnt++; pending cleared.
- If pending sets in the same cycle as a vsync edge, the commit waits for the next vsync edge.
- Write bank is always ~rd_bank. A commit can only occur outside RECV, because RECV cannot start while pending.
- Reset mid-frame: everything returns to reset values and no further write is issued. RAM contents are untouched.

Decomposition:
- Shared package zx_pkg: PIXEL_BYTES, ATTR_BYTES, INFO_BYTES, FRAME_BYTES, BORDER_OFFSET, loader state encoding. The renderer reuses the same constants.
- Sub-module spi_sampler: 2-FF synchronizers, edge detection, 8-bit shift register.
  - Outputs: byte_valid pulse, byte, cs_fall, cs_rise.
  - Takes a clear input, driven on cs_fall, to reset the bit count.
- The top contains the FSM, byte index, bank and commit logic.

Test Plan:
- Full frame: send 7168 bytes (value = idx[7:0], byte 7040 = 8'h05), then raise cs.
  - Expect exactly 7168 wr_en pulses, addresses 0x2000..0x3BFF (bank 1), rd_bank still 0.
  - On the next vsync edge: rd_bank=1, border=3'b101, frame_cnt=1.
- Short frame: send 100 bytes plus 3 bits, then raise cs.
  - Expect 100 writes, one short_err pulse, no commit at vsync, border still 3'b111.
- Overrun: send 7170 bytes in one cs window.
  - Expect 7168 writes, none for bytes 7168-7169, and a single commit.
- Pending drop: two full frames with no vsync in between.
  - Expect the second frame to produce no writes, drop_cnt=1; the first frame commits at vsync.
- Coincident completion: final write lands in the same cycle as a vsync edge.
  - Expect no commit that cycle; commit at the following vsync.
- Reset mid-frame: assert RST after 500 bytes.
  - Expect all outputs back at reset values and no further writes until a new cs fall.
  - A subsequent full frame writes bank 1 from index 0.

Source files
------------

// File: rtl/zx_pkg.sv
// Shared ZX frame geometry and loader state encoding, used by the loader and the renderer.
package zx_pkg;

    localparam int PIXEL_BYTES   = 6144;
    localparam int ATTR_BYTES    = 768;
    localparam int INFO_BYTES    = 256;
    localparam int FRAME_BYTES   = PIXEL_BYTES + ATTR_BYTES + INFO_BYTES;
    localparam int BORDER_OFFSET = 7040;
    localparam int AW            = 13;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_DONE,
        ST_SKIP
    } loader_state_t;

endpackage

// File: rtl/spi_sampler.sv
// Oversamples raw SPI pins in the pixel-clock domain and assembles MSB-first bytes.
module spi_sampler (
    input  logic       PixelClk,
    input  logic       RST,
    input  logic       spi_clk,
    input  logic       spi_dat,
    input  logic       spi_cs,
    input  logic       clear,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       cs_fall,
    output logic       cs_rise
);

    logic       clk_s1, clk_s2, clk_s3;
    logic       cs_s1, cs_s2, cs_s3;
    logic       dat_s1, dat_s2;
    logic [2:0] bit_cnt;
    logic [6:0] shreg;
    logic       clk_rise;

    // Idle levels: clock low, chip select released.
    always_ff @(posedge PixelClk or posedge RST) begin
        if (RST) begin
            clk_s1 <= 1'b0; clk_s2 <= 1'b0; clk_s3 <= 1'b0;
            cs_s1  <= 1'b1; cs_s2  <= 1'b1; cs_s3  <= 1'b1;
            dat_s1 <= 1'b0; dat_s2 <= 1'b0;
        end else begin
            clk_s1 <= spi_clk; clk_s2 <= clk_s1; clk_s3 <= clk_s2;
            cs_s1  <= spi_cs;  cs_s2  <= cs_s1;  cs_s3  <= cs_s2;
            dat_s1 <= spi_dat; dat_s2 <= dat_s1;
        end
    end

    assign clk_rise = clk_s2 & ~clk_s3;
    assign cs_fall  = ~cs_s2 & cs_s3;
    assign cs_rise  = cs_s2 & ~cs_s3;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge PixelClk or posedge RST) begin
        if (RST) begin
            bit_cnt    <= 3'd0;
            shreg      <= 7'd0;
            byte_valid <= 1'b0;
            rx_byte    <= 8'd0;
        end else begin
            byte_valid <= 1'b0;
            if (clear) begin
                bit_cnt <= 3'd0;
            end else if (clk_rise && !cs_s2) begin
                shreg   <= {shreg[5:0], dat_s2};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_valid <= 1'b1;
                    rx_byte    <= {shreg, dat_s2};
                end
            end
        end
    end

endmodule

// File: rtl/zx_frame_loader.sv
// Sequences SPI frame uploads into the back bank of a double-buffered frame RAM and commits at vsync.
module zx_frame_loader
    import zx_pkg::*;
#(
    parameter int FRAME_LEN  = FRAME_BYTES,
    parameter int BORDER_IDX = BORDER_OFFSET,
    parameter int ADDR_W     = AW
) (
    input  logic              PixelClk,
    input  logic              RST,
    input  logic              spi_clk,
    input  logic              spi_dat,
    input  logic              spi_cs,
    input  logic              vsync,
    output logic              wr_en,
    output logic [ADDR_W:0]   wr_addr,
    output logic [7:0]        wr_data,
    output logic              rd_bank,
    output logic [2:0]        border,
    output logic [7:0]        frame_cnt,
    output logic              short_err,
    output logic [7:0]        drop_cnt
);

    loader_state_t     state, state_nxt;
    logic              byte_valid, cs_fall, cs_rise;
    logic [7:0]        rx_byte;
    logic [ADDR_W-1:0] idx;
    logic              pending, vsync_q, commit;
    logic [2:0]        border_shadow;
    logic              start_recv, start_skip, do_write, last_byte, short_pulse;

    spi_sampler u_sampler (
        .PixelClk   (PixelClk),
        .RST        (RST),
        .spi_clk    (spi_clk),
        .spi_dat    (spi_dat),
        .spi_cs     (spi_cs),
        .clear      (cs_fall),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .cs_fall    (cs_fall),
        .cs_rise    (cs_rise)
    );

    always_ff @(posedge PixelClk or posedge RST) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        start_recv  = 1'b0;
        start_skip  = 1'b0;
        do_write    = 1'b0;
        last_byte   = 1'b0;
        short_pulse = 1'b0;
        case (state)
            ST_IDLE: if (cs_fall) begin
                if (pending) begin
                    state_nxt  = ST_SKIP;
                    start_skip = 1'b1;
                end else begin
                    state_nxt  = ST_RECV;
                    start_recv = 1'b1;
                end
            end
            ST_RECV: begin
                if (byte_valid) begin
                    do_write = 1'b1;
                    if (idx == ADDR_W'(FRAME_LEN - 1)) begin
                        last_byte = 1'b1;
                        state_nxt = ST_DONE;
                    end
                end
                // A release that coincides with the final byte is a complete frame, not a short one.
                if (cs_rise) begin
                    state_nxt   = ST_IDLE;
                    short_pulse = !last_byte;
                end
            end
            ST_DONE, ST_SKIP: if (cs_rise) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // pending is the pre-edge value, so a frame finishing on a vsync edge waits for the next one.
    assign commit = vsync & ~vsync_q & pending;

    always_ff @(posedge PixelClk or posedge RST) begin
        if (RST) begin
            wr_en         <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= 8'd0;
            rd_bank       <= 1'b0;
            border        <= 3'b111;
            border_shadow <= 3'b111;
            frame_cnt     <= 8'd0;
            drop_cnt      <= 8'd0;
            short_err     <= 1'b0;
            idx           <= '0;
            pending       <= 1'b0;
            vsync_q       <= 1'b0;
        end else begin
            vsync_q   <= vsync;
            wr_en     <= do_write;
            short_err <= short_pulse;
            if (start_recv) idx <= '0;
            if (start_skip && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            if (do_write) begin
                wr_addr <= {~rd_bank, idx};
                wr_data <= rx_byte;
                idx     <= idx + 1'b1;
                if (idx == ADDR_W'(BORDER_IDX)) border_shadow <= rx_byte[2:0];
            end
            if (commit) begin
                rd_bank   <= ~rd_bank;
                border    <= border_shadow;
                frame_cnt <= frame_cnt + 8'd1;
                pending   <= 1'b0;
            end
            if (last_byte) pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_zx_frame_loader.sv
// Directed scoreboard bench for zx_frame_loader: uploads, short frames, overrun, drops, vsync timing, reset.
module tb_zx_frame_loader;

    // Reduced frame geometry keeps uploads short; the 13-bit index width matches the real design.
    localparam int FL = 96;
    localparam int BI = 88;

    logic        PixelClk = 1'b0;
    logic        RST;
    logic        spi_clk, spi_dat, spi_cs, vsync;
    logic        wr_en;
    logic [13:0] wr_addr;
    logic [7:0]  wr_data;
    logic        rd_bank;
    logic [2:0]  border;
    logic [7:0]  frame_cnt;
    logic        short_err;
    logic [7:0]  drop_cnt;

    int checks   = 0;
    int failures = 0;
    int wr_total = 0;
    int err_total = 0;
    logic [21:0] exp_q[$];

    zx_frame_loader #(.FRAME_LEN(FL), .BORDER_IDX(BI), .ADDR_W(13)) dut (
        .PixelClk  (PixelClk),
        .RST       (RST),
        .spi_clk   (spi_clk),
        .spi_dat   (spi_dat),
        .spi_cs    (spi_cs),
        .vsync     (vsync),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_bank   (rd_bank),
        .border    (border),
        .frame_cnt (frame_cnt),
        .short_err (short_err),
        .drop_cnt  (drop_cnt)
    );

    always #5 PixelClk = ~PixelClk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected {addr, data}.
    always @(negedge PixelClk) begin
        logic [21:0] e;
        if (wr_en) begin
            wr_total++;
            check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e[21:8]));
                check("wr_data", 32'(wr_data), 32'(e[7:0]));
            end
        end
        if (short_err) err_total++;
    end

    // Called at a falling PixelClk edge: low for 2 cycles, high for 2 cycles.
    task automatic spi_bit(input logic b);
        spi_dat = b;
        spi_clk = 1'b0;
        repeat (2) @(negedge PixelClk);
        spi_clk = 1'b1;
        repeat (2) @(negedge PixelClk);
    endtask

    task automatic spi_byte(input logic [7:0] v);
        for (int b = 7; b >= 0; b--) spi_bit(v[b]);
    endtask

    task automatic cs_low();
        spi_clk = 1'b0;
        spi_cs  = 1'b0;
        repeat (4) @(negedge PixelClk);
    endtask

    task automatic cs_high();
        spi_clk = 1'b0;
        repeat (2) @(negedge PixelClk);
        spi_cs = 1'b1;
        repeat (8) @(negedge PixelClk);
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1;
        repeat (2) @(negedge PixelClk);
        vsync = 1'b0;
        repeat (2) @(negedge PixelClk);
    endtask

    // Sends n_bytes; the first n_wr are expected in bank `bank`. Byte BI carries the border colour.
    task automatic send_frame(input int n_bytes, input int n_wr, input logic bank, input logic [2:0] bval);
        for (int i = 0; i < n_bytes; i++) begin
            logic [7:0] v;
            v = (i == BI) ? {5'b10100, bval} : i[7:0];
            if (i < n_wr) exp_q.push_back({bank, 13'(i), v});
            spi_byte(v);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_wr_en"},     32'(wr_en),     32'd0);
        check({tag, "_wr_addr"},   32'(wr_addr),   32'd0);
        check({tag, "_wr_data"},   32'(wr_data),   32'd0);
        check({tag, "_rd_bank"},   32'(rd_bank),   32'd0);
        check({tag, "_border"},    32'(border),    32'd7);
        check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
        check({tag, "_drop_cnt"},  32'(drop_cnt),  32'd0);
        check({tag, "_short_err"}, 32'(short_err), 32'd0);
    endtask

    initial begin
        int w0, e0;
        logic [7:0] lv;
        RST = 1'b1; spi_clk = 1'b0; spi_dat = 1'b0; spi_cs = 1'b1; vsync = 1'b0;
        repeat (3) @(negedge PixelClk);
        check_reset_values("reset");
        RST = 1'b0;
        repeat (3) @(negedge PixelClk);
        check_reset_values("post_reset");

        // Short frame: 20 bytes plus 3 stray bits, into bank 1.
        w0 = wr_total; e0 = err_total;
        cs_low();
        send_frame(20, 20, 1'b1, 3'd0);
        spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1);
        cs_high();
        check("short_writes", 32'(wr_total - w0), 32'd20);
        check("short_err_pulses", 32'(err_total - e0), 32'd1);
        check("short_queue", 32'(exp_q.size()), 32'd0);
        vsync_pulse();
        check("short_rd_bank", 32'(rd_bank), 32'd0);
        check("short_border", 32'(border), 32'd7);
        check("short_frame_cnt", 32'(frame_cnt), 32'd0);

        // Full frame into bank 1, border 5.
        w0 = wr_total;
        cs_low();
        send_frame(FL, FL, 1'b1, 3'd5);
        cs_high();
        check("full_writes", 32'(wr_total - w0), 32'(FL));
        check("full_queue", 32'(exp_q.size()), 32'd0);
        check("full_rd_bank_pre", 32'(rd_bank), 32'd0);
        check("full_frame_cnt_pre", 32'(frame_cnt), 32'd0);
        vsync_pulse();
        check("full_rd_bank", 32'(rd_bank), 32'd1);
        check("full_border", 32'(border), 32'd5);
        check("full_frame_cnt", 32'(frame_cnt), 32'd1);

        // Overrun: two extra bytes into bank 0 are ignored; exactly one commit.
        w0 = wr_total;
        cs_low();
        send_frame(FL + 2, FL, 1'b0, 3'd3);
        cs_high();
        check("overrun_writes", 32'(wr_total - w0), 32'(FL));
        check("overrun_queue", 32'(exp_q.size()), 32'd0);
        vsync_pulse();
        vsync_pulse();
        check("overrun_rd_bank", 32'(rd_bank), 32'd0);
        check("overrun_border", 32'(border), 32'd3);
        check("overrun_frame_cnt", 32'(frame_cnt), 32'd2);

        // Pending drop: second frame arrives before vsync and is skipped.
        w0 = wr_total;
        cs_low();
        send_frame(FL, FL, 1'b1, 3'd6);
        cs_high();
        cs_low();
        send_frame(FL, 0, 1'b1, 3'd1);
        cs_high();
        check("drop_writes", 32'(wr_total - w0), 32'(FL));
        check("drop_cnt", 32'(drop_cnt), 32'd1);
        check("drop_frame_cnt_pre", 32'(frame_cnt), 32'd2);
        vsync_pulse();
        check("drop_rd_bank", 32'(rd_bank), 32'd1);
        check("drop_border", 32'(border), 32'd6);
        check("drop_frame_cnt", 32'(frame_cnt), 32'd3);

        // Coincident completion: vsync edge in the cycle the final write strobe appears.
        cs_low();
        send_frame(FL - 1, FL - 1, 1'b0, 3'd2);
        lv = 8'(FL - 1);
        exp_q.push_back({1'b0, 13'(FL - 1), lv});
        for (int b = 7; b >= 1; b--) spi_bit(lv[b]);
        spi_dat = lv[0];
        spi_clk = 1'b0;
        repeat (2) @(negedge PixelClk);
        spi_clk = 1'b1;
        repeat (3) @(negedge PixelClk);
        check("latency_wr_en_early", 32'(wr_en), 32'd0);
        vsync = 1'b1;
        @(negedge PixelClk);
        check("latency_wr_en", 32'(wr_en), 32'd1);
        check("coincident_rd_bank", 32'(rd_bank), 32'd1);
        repeat (2) @(negedge PixelClk);
        vsync = 1'b0;
        cs_high();
        check("coincident_frame_cnt_pre", 32'(frame_cnt), 32'd3);
        check("coincident_queue", 32'(exp_q.size()), 32'd0);
        vsync_pulse();
        check("coincident_rd_bank_post", 32'(rd_bank), 32'd0);
        check("coincident_border", 32'(border), 32'd2);
        check("coincident_frame_cnt", 32'(frame_cnt), 32'd4);

        // Reset mid-frame, then idle clocking with cs released must not write.
        cs_low();
        send_frame(40, 40, 1'b1, 3'd0);
        spi_bit(1'b1); spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1);
        RST = 1'b1;
        @(negedge PixelClk);
        check_reset_values("midreset");
        spi_cs = 1'b1;
        repeat (2) @(negedge PixelClk);
        RST = 1'b0;
        w0 = wr_total;
        spi_byte(8'hA5);
        spi_byte(8'h3C);
        spi_clk = 1'b0;
        repeat (8) @(negedge PixelClk);
        check("midreset_no_writes", 32'(wr_total - w0), 32'd0);
        check("midreset_queue", 32'(exp_q.size()), 32'd0);
        check_reset_values("after_midreset");

        // Fresh full frame lands in bank 1 from index 0.
        w0 = wr_total;
        cs_low();
        send_frame(FL, FL, 1'b1, 3'd4);
        cs_high();
        check("refill_writes", 32'(wr_total - w0), 32'(FL));
        check("refill_queue", 32'(exp_q.size()), 32'd0);
        vsync_pulse();
        check("refill_rd_bank", 32'(rd_bank), 32'd1);
        check("refill_border", 32'(border), 32'd4);
        check("refill_frame_cnt", 32'(frame_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
